srt_divider_param: RTL and testbench

- Parametrised iterative integer divider for the RV64M/RV32M execute stage.
- Successor to the fixed 64-bit divider: configurable operand width and digits per cycle, and valid/ready handshakes on both request and response.
- Implements RISC-V DIV/DIVU/REM/REMU, plus *W word ops when XLEN=64.
- Adds divide-by-zero and overflow early-out, a flush input and tag passthrough.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step_slice.sv | 24 ++
 rtl/srt_divider_param.sv | 138 +++++++++++++
 tb/tb_srt_divider_param.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the parametrised iterative divider.
package div_pkg;
  typedef enum logic [1:0] {DIV, DIVU, REM, REMU} div_op_e;
  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} div_state_e;
  // Most-negative W-bit value, sign-extended to 64 bits so truncation to any XLEN stays correct.
  function automatic logic [63:0] most_negative(input int unsigned w);
    return ~64'd0 << (w - 1);
  endfunction
  function automatic logic [63:0] sext32(input logic [31:0] x, input logic s);
    return {{32{s & x[31]}}, x};
  endfunction
endpackage

// File: rtl/div_step_slice.sv
// div_step_slice: BITS_PER_CYCLE unrolled restoring division steps, MSB first.
module div_step_slice #(
  parameter int XLEN = 64,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic [XLEN+BITS_PER_CYCLE-1:0] rem_i,
  input  logic [BITS_PER_CYCLE-1:0]      bits_i,
  input  logic [XLEN-1:0]                div_i,
  output logic [XLEN+BITS_PER_CYCLE-1:0] rem_o,
  output logic [BITS_PER_CYCLE-1:0]      q_o
);
  localparam int RW = XLEN + BITS_PER_CYCLE;
  logic [RW-1:0] d_ext;
  assign d_ext = {{BITS_PER_CYCLE{1'b0}}, div_i};
  always_comb begin
    rem_o = rem_i;
    q_o = '0;
    for (int i = BITS_PER_CYCLE - 1; i >= 0; i--) begin
      rem_o = {rem_o[RW-2:0], bits_i[i]};
      q_o[i] = rem_o >= d_ext;
      rem_o = q_o[i] ? rem_o - d_ext : rem_o;
    end
  end
endmodule

// File: rtl/srt_divider_param.sv
// srt_divider_param: iterative RISC-V DIV/DIVU/REM/REMU(+W) divider with valid/ready,
// flush, tag passthrough and early-out for divide-by-zero and signed overflow.
module srt_divider_param
  import div_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int BITS_PER_CYCLE = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  localparam int B = BITS_PER_CYCLE;
  localparam int CW = $clog2(XLEN / B + 1);
  div_state_e state_q, state_d;
  div_op_e op_q, op_d;
  logic word_q, word_d, sa_q, sa_d, sb_q, sb_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
  logic [XLEN+B-1:0] rem_q, rem_d, rem_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [B-1:0] q_bits;
  logic sgn, is_rem, sa, sb, b_zero, ovf;
  logic [XLEN-1:0] ext_a, ext_b, abs_a, abs_b, special, q_fix, r_fix;
  function automatic logic [XLEN-1:0] wsext(input logic w, input logic [XLEN-1:0] x);
    return w ? XLEN'(sext32(x[31:0], 1'b1)) : x;
  endfunction
  assign sgn = (op_q == DIV) || (op_q == REM);
  assign is_rem = (op_q == REM) || (op_q == REMU);
  assign ext_a = word_q ? XLEN'(sext32(a_q[31:0], sgn)) : a_q;
  assign ext_b = word_q ? XLEN'(sext32(b_q[31:0], sgn)) : b_q;
  assign sa = sgn & ext_a[XLEN-1];
  assign sb = sgn & ext_b[XLEN-1];
  assign abs_a = sa ? -ext_a : ext_a;
  assign abs_b = sb ? -ext_b : ext_b;
  assign b_zero = ext_b == '0;
  assign ovf = sgn && (ext_a == XLEN'(most_negative(word_q ? 32 : XLEN))) && (ext_b == '1);
  assign special = b_zero ? (is_rem ? ext_a : '1) : (is_rem ? '0 : ext_a);
  // After ITER the dividend register holds the unsigned quotient.
  assign q_fix = (sa_q ^ sb_q) ? -a_q : a_q;
  assign r_fix = sa_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  div_step_slice #(.XLEN(XLEN), .BITS_PER_CYCLE(B)) u_step (
    .rem_i(rem_q), .bits_i(a_q[XLEN-1 -: B]), .div_i(b_q), .rem_o(rem_nx), .q_o(q_bits)
  );
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    word_d = word_q;
    sa_d = sa_q;
    sb_d = sb_q;
    tag_d = tag_q;
    a_d = a_q;
    b_d = b_q;
    data_d = data_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = PREP;
        op_d = div_op_e'(req_op);
        word_d = req_word && (XLEN == 64);
        tag_d = req_tag;
        a_d = req_a;
        b_d = req_b;
      end
      PREP: if (b_zero || ovf) begin
        state_d = DONE;
        data_d = wsext(word_q, special);
      end else begin
        state_d = ITER;
        sa_d = sa;
        sb_d = sb;
        a_d = word_q ? abs_a << (XLEN - 32) : abs_a;
        b_d = abs_b;
        rem_d = '0;
        cnt_d = word_q ? CW'(32 / B) : CW'(XLEN / B);
      end
      ITER: begin
        a_d = {a_q[XLEN-B-1:0], q_bits};
        rem_d = rem_nx;
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == 1) ? FIX : ITER;
      end
      FIX: begin
        data_d = wsext(word_q, is_rem ? r_fix : q_fix);
        state_d = DONE;
      end
      DONE: state_d = resp_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    state_d = flush ? IDLE : state_d;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= DIV;
      word_q <= 1'b0;
      sa_q <= 1'b0;
      sb_q <= 1'b0;
      tag_q <= '0;
      a_q <= '0;
      b_q <= '0;
      data_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      word_q <= word_d;
      sa_q <= sa_d;
      sb_q <= sb_d;
      tag_q <= tag_d;
      a_q <= a_d;
      b_q <= b_d;
      data_q <= data_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign resp_valid = state_q == DONE;
  assign resp_data = resp_valid ? data_q : '0;
  assign resp_tag = resp_valid ? tag_q : '0;
endmodule

// File: tb/tb_srt_divider_param.sv
// tb_srt_divider_param: randomized and directed checks of the divider against an arithmetic model.
module tb_srt_divider_param;
  logic clk = 0, rst_n = 0, flush = 0, req_valid = 0, req_word = 0, resp_ready = 0;
  logic [1:0] req_op = 0;
  logic [63:0] req_a = 0, req_b = 0;
  logic [3:0] req_tag = 0;
  logic req_ready, resp_valid, busy;
  logic [63:0] resp_data;
  logic [3:0] resp_tag;
  int checks = 0, errors = 0;

  srt_divider_param #(.XLEN(64), .BITS_PER_CYCLE(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_word(req_word), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_div(input logic [1:0] op, input logic w, input logic [63:0] a, b);
    longint sa, sb;
    logic [63:0] ua, ub, q, r, res;
    ua = w ? {32'b0, a[31:0]} : a;
    ub = w ? {32'b0, b[31:0]} : b;
    sa = w ? longint'($signed(a[31:0])) : $signed(a);
    sb = w ? longint'($signed(b[31:0])) : $signed(b);
    if (!op[0]) begin
      if (sb == 0) begin q = '1; r = sa; end
      else if (sb == -1) begin q = -sa; r = 0; end
      else begin q = sa / sb; r = sa % sb; end
    end else begin
      if (ub == 0) begin q = '1; r = ua; end
      else begin q = ua / ub; r = ua % ub; end
    end
    res = op[1] ? r : q;
    return w ? {{32{res[31]}}, res[31:0]} : res;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic w, input logic [63:0] a, b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 0) : (b == 0);
    ovf = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                       : (a == 64'h8000_0000_0000_0000 && b == '1));
    return (zero || ovf) ? 1 : (w ? 32 : 64) / 2 + 2;
  endfunction

  task automatic start(input logic [1:0] op, input logic w, input logic [63:0] a, b, input logic [3:0] t);
    @(negedge clk);
    req_valid = 1; req_op = op; req_word = w; req_a = a; req_b = b; req_tag = t;
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain();
    @(negedge clk);
    resp_ready = 1;
    @(posedge clk); #1;
    resp_ready = 0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (resp_valid !== 0) begin errors++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (resp_data !== 0) begin errors++; $display("FAIL reset_data got %h exp 0", resp_data); end
    checks++; if (resp_tag !== 0) begin errors++; $display("FAIL reset_tag got %h exp 0", resp_tag); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
  endtask

  typedef struct { logic [1:0] op; logic w; logic [63:0] a, b, exp; int lat; } vec_t;

  task automatic test_directed();
    vec_t v[8];
    int lat;
    v[0] = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34};
    v[1] = '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    v[2] = '{2'd1, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    v[3] = '{2'd3, 1'b0, 64'h1234, 64'd0, 64'h1234, 1};
    v[4] = '{2'd0, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1};
    v[5] = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1};
    v[6] = '{2'd0, 1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
    v[7] = '{2'd1, 1'b1, 64'hFFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 18};
    for (int i = 0; i < 8; i++) begin
      start(v[i].op, v[i].w, v[i].a, v[i].b, 4'(i + 5));
      wait_resp(lat);
      checks++; if (resp_data !== v[i].exp) begin errors++; $display("FAIL dir%0d_data got %h exp %h", i, resp_data, v[i].exp); end
      checks++; if (resp_tag !== 4'(i + 5)) begin errors++; $display("FAIL dir%0d_tag got %0d exp %0d", i, resp_tag, i + 5); end
      checks++; if (lat !== v[i].lat) begin errors++; $display("FAIL dir%0d_lat got %0d exp %0d", i, lat, v[i].lat); end
      drain();
    end
  endtask

  task automatic test_random();
    logic [63:0] a, b;
    logic [1:0] op;
    logic w;
    logic [3:0] t;
    int lat, sel;
    for (int i = 0; i < 40; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom} >> $urandom_range(63, 0);
      op = 2'($urandom_range(3, 0));
      w = 1'($urandom_range(1, 0));
      t = 4'($urandom);
      sel = $urandom_range(7, 0);
      if (sel == 0) b = 0;
      if (sel == 1) b = '1;
      if (sel == 2) begin a = w ? 64'h8000_0000 : 64'h8000_0000_0000_0000; b = '1; end
      if (sel == 3) a = -a;
      start(op, w, a, b, t);
      wait_resp(lat);
      checks++; if (resp_data !== ref_div(op, w, a, b)) begin errors++; $display("FAIL rnd%0d_data op %0d w %b a %h b %h got %h exp %h", i, op, w, a, b, resp_data, ref_div(op, w, a, b)); end
      checks++; if (resp_tag !== t) begin errors++; $display("FAIL rnd%0d_tag got %0d exp %0d", i, resp_tag, t); end
      checks++; if (lat !== ref_lat(op, w, a, b)) begin errors++; $display("FAIL rnd%0d_lat got %0d exp %0d", i, lat, ref_lat(op, w, a, b)); end
      drain();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    start(2'd1, 1'b0, 64'd100, 64'd7, 4'd3);
    wait_resp(lat);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (resp_data !== 64'd14 || resp_valid !== 1 || req_ready !== 0 || resp_tag !== 4'd3) begin
        errors++;
        $display("FAIL hold%0d data %0d valid %b ready %b tag %0d exp 14 1 0 3", i, resp_data, resp_valid, req_ready, resp_tag);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    resp_ready = 1; req_valid = 1; req_op = 2'd1; req_a = 64'd9; req_b = 64'd3;
    @(posedge clk); #1;
    resp_ready = 0; req_valid = 0;
    checks++; if (resp_valid !== 0) begin errors++; $display("FAIL release_valid got %b exp 0", resp_valid); end
    checks++; if (busy !== 0) begin errors++; $display("FAIL release_no_accept busy got %b exp 0", busy); end
    checks++; if (req_ready !== 1) begin errors++; $display("FAIL release_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_flush();
    int lat;
    start(2'd1, 1'b0, 64'hFFFF_0000_1234_5678, 64'd12345, 4'd9);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (busy !== 1) begin errors++; $display("FAIL flush_busy_before got %b exp 1", busy); end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    checks++; if (resp_valid !== 0 || busy !== 0) begin errors++; $display("FAIL flush_iter valid %b busy %b exp 0 0", resp_valid, busy); end
    start(2'd3, 1'b0, 64'd100, 64'd7, 4'd2);
    wait_resp(lat);
    checks++; if (resp_data !== 64'd2) begin errors++; $display("FAIL flush_after_data got %0d exp 2", resp_data); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL flush_after_lat got %0d exp 34", lat); end
    @(negedge clk) flush = 1;
    @(posedge clk); #1;
    flush = 0;
    checks++; if (resp_valid !== 0 || resp_data !== 0) begin errors++; $display("FAIL flush_done valid %b data %h exp 0 0", resp_valid, resp_data); end
    @(negedge clk);
    req_valid = 1; flush = 1; req_op = 2'd1; req_a = 64'd5; req_b = 64'd1;
    @(posedge clk); #1;
    req_valid = 0; flush = 0;
    checks++; if (busy !== 0) begin errors++; $display("FAIL flush_idle busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int lat;
    start(2'd0, 1'b0, 64'h7654_3210_FEDC_BA98, 64'd77, 4'd6);
    repeat (6) @(posedge clk);
    #2 rst_n = 0;
    #1;
    checks++; if (resp_valid !== 0 || busy !== 0) begin errors++; $display("FAIL rst_mid valid %b busy %b exp 0 0", resp_valid, busy); end
    checks++; if (resp_data !== 0) begin errors++; $display("FAIL rst_mid_data got %h exp 0", resp_data); end
    @(negedge clk) rst_n = 1;
    start(2'd3, 1'b0, 64'd100, 64'd7, 4'd1);
    wait_resp(lat);
    checks++; if (resp_data !== 64'd2) begin errors++; $display("FAIL rst_after_data got %0d exp 2", resp_data); end
    drain();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
